// File: rtl/fifo_egress_scheduler.sv
// -----------------------------------------------------------------------------
// fifo_egress_scheduler
//
// Round-robin drain of NUM_PORTS standard-mode (non fall-through) ingress
// FIFOs onto one egress word stream. One port is granted at a time for a burst
// of up to MAX_BURST words; each word costs a READ cycle (strobe), a LOAD cycle
// (FIFO read_data becomes valid and is captured) and a SEND cycle (held until
// output_ready). Rotation resumes from the port after the last granted one.
//
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   enable                allows new grants (sampled only in IDLE)
//   fifo_empty            per-FIFO empty flags
//   fifo_read_data        per-FIFO read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   fifo_read_enable      one-hot read strobe, asserted only in READ
//   output_data/_port     egress word and its source port
//   output_last           final word of the current burst
//   output_valid/_ready   egress handshake (valid is registered)
//   busy                  scheduler is not IDLE
// -----------------------------------------------------------------------------
module fifo_egress_scheduler #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic [NUM_PORTS-1:0]             fifo_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  fifo_read_data,
  output logic [NUM_PORTS-1:0]             fifo_read_enable,
  output logic [DATA_WIDTH-1:0]            output_data,
  output logic [$clog2(NUM_PORTS)-1:0]     output_port,
  output logic                             output_last,
  output logic                             output_valid,
  input  logic                             output_ready,
  output logic                             busy
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int BC_W   = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_e;

  state_e                 state_q;
  logic [PORT_W-1:0]      grant_q;
  logic [PORT_W-1:0]      last_grant_q;
  logic [BC_W-1:0]        burst_count_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [PORT_W-1:0]      port_q;
  logic                   last_q;
  logic                   valid_q;

  logic [PORT_W-1:0]      next_grant_d;
  logic                   found_d;
  logic [DATA_WIDTH-1:0]  grant_word;

  // First non-empty port after last_grant_q, wrapping NUM_PORTS-1 -> 0.
  // NOTE: every combinational output gets a default before any branch so no
  // latch is inferred when no port qualifies.
  always_comb begin
    next_grant_d = last_grant_q;
    found_d      = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      int idx;
      idx = (int'(last_grant_q) + k) % NUM_PORTS;
      if (!found_d && !fifo_empty[idx]) begin
        next_grant_d = PORT_W'(idx);
        found_d      = 1'b1;
      end
    end
  end

  assign grant_word = fifo_read_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

  // Strobe is decoded from the state register, so it is glitch-free and held
  // low whenever reset forces the FSM to IDLE.
  always_comb begin
    fifo_read_enable = '0;
    if (state_q == READ) begin
      fifo_read_enable[grant_q] = 1'b1;
    end
  end

  // NOTE: state and output registers use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= PORT_W'(NUM_PORTS - 1);
      burst_count_q <= '0;
      data_q        <= '0;
      port_q        <= '0;
      last_q        <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable && found_d) begin
            grant_q       <= next_grant_d;
            burst_count_q <= '0;
            state_q       <= READ;
          end
        end
        READ: begin
          state_q <= LOAD;
        end
        LOAD: begin
          // read_data is valid the cycle after the strobe; fifo_empty now
          // reflects the word just removed, so an empty FIFO ends the burst.
          data_q  <= grant_word;
          port_q  <= grant_q;
          valid_q <= 1'b1;
          last_q  <= (burst_count_q == BC_W'(MAX_BURST - 1)) || fifo_empty[grant_q];
          state_q <= SEND;
        end
        SEND: begin
          if (output_ready) begin
            valid_q       <= 1'b0;
            burst_count_q <= burst_count_q + BC_W'(1);
            if (last_q) begin
              last_grant_q <= grant_q;
              state_q      <= IDLE;
            end else begin
              state_q <= READ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign output_data  = data_q;
  assign output_port  = port_q;
  assign output_last  = last_q;
  assign output_valid = valid_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_egress_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fifo_egress_scheduler
//
// Directed scenarios plus randomized rounds. Ingress FIFOs are modelled as
// arrays with read/write pointers (standard mode: data one cycle after the
// strobe). The reference model works on whole bursts: pick the next non-empty
// port after the last grant, take min(MAX_BURST, words queued) words, mark
// the final one last.
// -----------------------------------------------------------------------------
module tb_fifo_egress_scheduler;

  localparam int NP    = 4;
  localparam int DW    = 16;
  localparam int MB    = 2;
  localparam int DEPTH = 256;
  localparam int PW    = $clog2(NP);

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic               output_ready = 1'b0;
  logic [NP-1:0]      fifo_empty;
  logic [NP*DW-1:0]   fifo_read_data;
  logic [NP-1:0]      fifo_read_enable;
  logic [DW-1:0]      output_data;
  logic [PW-1:0]      output_port;
  logic               output_last;
  logic               output_valid;
  logic               busy;

  fifo_egress_scheduler #(
    .NUM_PORTS  (NP),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .enable           (enable),
    .fifo_empty       (fifo_empty),
    .fifo_read_data   (fifo_read_data),
    .fifo_read_enable (fifo_read_enable),
    .output_data      (output_data),
    .output_port      (output_port),
    .output_last      (output_last),
    .output_valid     (output_valid),
    .output_ready     (output_ready),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  // ---------------- ingress FIFO models ----------------
  logic [DW-1:0] mem [NP][DEPTH];
  int            wr_ptr [NP] = '{default: 0};
  int            rd_ptr [NP] = '{default: 0};
  logic [DW-1:0] rd_data [NP] = '{default: '0};
  int            n_badread = 0;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      fifo_empty[p]              = (wr_ptr[p] == rd_ptr[p]);
      fifo_read_data[p*DW +: DW] = rd_data[p];
    end
  end

  always @(posedge clock) begin
    for (int p = 0; p < NP; p++) begin
      if (fifo_read_enable[p]) begin
        if (wr_ptr[p] == rd_ptr[p]) begin
          n_badread <= n_badread + 1;
        end else begin
          rd_data[p] <= mem[p][rd_ptr[p] % DEPTH];
          rd_ptr[p]  <= rd_ptr[p] + 1;
        end
      end
    end
  end

  // ---------------- egress monitor ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] port;
    logic          last;
    int            cyc;
  } word_t;

  word_t obs[$];
  int    cyc = 0;
  int    strobe_cnt = 0;
  int    bad_strobe = 0;
  int    ready_mode = 0;   // 0: always ready, 1: random, 2: held low

  // Ready is driven on the falling edge; a word seen valid&&ready here is
  // accepted on the next rising edge.
  always @(negedge clock) begin
    case (ready_mode)
      0:       output_ready = 1'b1;
      1:       output_ready = ($urandom_range(0, 3) != 0);
      default: output_ready = 1'b0;
    endcase
    if (output_valid && output_ready) begin
      obs.push_back('{output_data, output_port, output_last, cyc});
    end
    cyc <= cyc + 1;
    if (fifo_read_enable != '0) strobe_cnt <= strobe_cnt + 1;
    if (!$onehot0(fifo_read_enable) || (!reset_n && fifo_read_enable != '0)) begin
      bad_strobe <= bad_strobe + 1;
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] mq [NP][$];
  word_t         exp_q[$];
  int            last_g = NP - 1;
  int            obs_rd = 0;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic load(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      mem[p][wr_ptr[p] % DEPTH] = d;
      wr_ptr[p] = wr_ptr[p] + 1;
      mq[p].push_back(d);
    end
  endtask

  function automatic int next_port();
    for (int k = 1; k <= NP; k++) begin
      int q;
      q = (last_g + k) % NP;
      if (mq[q].size() > 0) return q;
    end
    return -1;
  endfunction

  task automatic model_burst(input int p);
    int n;
    n = (mq[p].size() < MB) ? mq[p].size() : MB;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{mq[p].pop_front(), PW'(p), (i == n - 1), 0});
    end
    last_g = p;
  endtask

  task automatic build_expected();
    int p;
    p = next_port();
    while (p >= 0) begin
      model_burst(p);
      p = next_port();
    end
  endtask

  task automatic compare_new();
    while (obs_rd < obs.size()) begin
      word_t w, e;
      w = obs[obs_rd];
      obs_rd++;
      check("word expected by model", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("word data", 32'(w.data), 32'(e.data));
        check("word port", 32'(w.port), 32'(e.port));
        check("word last", 32'(w.last), 32'(e.last));
      end
    end
  endtask

  task automatic drain(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      compare_new();
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    compare_new();
    check({tag, " completed within budget"}, 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    last_g  = NP - 1;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    for (int i = 0; i < budget && !output_valid; i++) step();
    check({tag, " valid seen"}, 32'(output_valid), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int sc;
    logic [DW-1:0] d0;
    logic [PW-1:0] seq_port [10];
    logic          seq_last [10];
    seq_port = '{0, 0, 2, 2, 0, 0, 2, 2, 0, 2};
    seq_last = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1};

    // Reset state
    step();
    step();
    check("reset strobe", 32'(fifo_read_enable), 32'd0);
    check("reset valid",  32'(output_valid), 32'd0);
    check("reset data",   32'(output_data), 32'd0);
    check("reset port",   32'(output_port), 32'd0);
    check("reset last",   32'(output_last), 32'd0);
    check("reset busy",   32'(busy), 32'd0);
    reset_n = 1'b1;
    step();
    check("idle busy after release", 32'(busy), 32'd0);

    // A: port 0 holds three words, ready always high
    ready_mode = 0;
    base = obs.size();
    sc   = strobe_cnt;
    load(0, 3);
    enable = 1'b1;
    build_expected();
    drain(200, "A");
    check("A word count", 32'(obs.size() - base), 32'd3);
    check("A strobe cycles", 32'(strobe_cnt - sc), 32'd3);
    if (obs.size() >= base + 2) begin
      check("A word spacing", 32'(obs[base+1].cyc - obs[base].cyc), 32'd3);
    end

    // B: ports 0 and 2, five words each, from reset priority
    enable = 1'b0;
    do_reset();
    base = obs.size();
    load(0, 5);
    load(2, 5);
    enable = 1'b1;
    build_expected();
    drain(400, "B");
    check("B word count", 32'(obs.size() - base), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (obs.size() > base + i) begin
        check($sformatf("B port seq %0d", i), 32'(obs[base+i].port), 32'(seq_port[i]));
        check($sformatf("B last seq %0d", i), 32'(obs[base+i].last), 32'(seq_last[i]));
      end
    end

    // C: backpressure for 10 cycles in SEND
    ready_mode = 2;
    load(1, 2);
    build_expected();
    wait_valid(50, "C");
    d0 = output_data;
    for (int i = 0; i < 10; i++) begin
      step();
      check("C valid held", 32'(output_valid), 32'd1);
      check("C data held", 32'(output_data), 32'(d0));
      check("C no strobe", 32'(fifo_read_enable), 32'd0);
    end
    ready_mode = 0;
    base = obs.size();
    step();
    check("C accepted on first ready", 32'(obs.size() - base), 32'd1);
    step();
    check("C valid dropped", 32'(output_valid), 32'd0);
    drain(200, "C");

    // D: enable low with every FIFO non-empty
    enable = 1'b0;
    do_reset();
    for (int p = 0; p < NP; p++) load(p, 2);
    sc = strobe_cnt;
    for (int i = 0; i < 6; i++) begin
      step();
      check("D busy while disabled", 32'(busy), 32'd0);
    end
    check("D no strobes while disabled", 32'(strobe_cnt - sc), 32'd0);
    base = obs.size();
    enable = 1'b1;
    build_expected();
    drain(600, "D");
    check("D words seen", 32'(obs.size() > base), 32'd1);
    if (obs.size() > base) check("D first grant", 32'(obs[base].port), 32'd0);

    // E: enable dropped mid-burst
    enable = 1'b0;
    load(1, 6);
    enable = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) step();
    check("E burst started", 32'(busy), 32'd1);
    enable = 1'b0;
    model_burst(1);
    drain(200, "E");
    sc = strobe_cnt;
    for (int i = 0; i < 10; i++) step();
    check("E stays idle", 32'(busy), 32'd0);
    check("E no strobes after burst", 32'(strobe_cnt - sc), 32'd0);
    check("E words left in FIFO", 32'(wr_ptr[1] - rd_ptr[1]), 32'(MB == 2 ? 4 : 6 - MB));
    enable = 1'b1;
    build_expected();
    drain(300, "E rest");

    // F: reset during SEND, then port 0 is granted before port 3
    enable = 1'b0;
    do_reset();
    load(0, 2);
    load(3, 2);
    ready_mode = 2;
    enable = 1'b1;
    wait_valid(50, "F");
    reset_n = 1'b0;
    #1;
    check("F reset valid",  32'(output_valid), 32'd0);
    check("F reset data",   32'(output_data), 32'd0);
    check("F reset port",   32'(output_port), 32'd0);
    check("F reset last",   32'(output_last), 32'd0);
    check("F reset busy",   32'(busy), 32'd0);
    check("F reset strobe", 32'(fifo_read_enable), 32'd0);
    void'(mq[0].pop_front());   // word in flight is lost by reset
    last_g = NP - 1;
    enable = 1'b0;
    step();
    step();
    reset_n    = 1'b1;
    ready_mode = 0;
    base = obs.size();
    enable = 1'b1;
    build_expected();
    drain(300, "F");
    check("F words seen", 32'(obs.size() > base), 32'd1);
    if (obs.size() > base) check("F first grant", 32'(obs[base].port), 32'd0);

    // Randomized rounds with random backpressure
    for (int r = 0; r < 8; r++) begin
      enable = 1'b0;
      for (int p = 0; p < NP; p++) load(p, $urandom_range(0, 5));
      ready_mode = 1;
      enable = 1'b1;
      build_expected();
      drain(1500, $sformatf("random round %0d", r));
    end
    ready_mode = 0;
    step();

    check("reads of empty FIFO", 32'(n_badread), 32'd0);
    check("illegal strobes", 32'(bad_strobe), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
